// File: rtl/xy_out_arbiter_if.sv
// Port bundle between one XY-mesh output arbiter, its requesting input FIFOs and
// the downstream router's input FIFO. The arbiter side uses the master modport.
interface xy_out_arbiter_if #(
    parameter int PORT_N = 5,
    parameter int PCKT_W = 16
);
    // Handshake: req_i[i] is the valid of input FIFO i's head, rd_en_o[i] is its pop
    // (only ever high while req_i[i] is high and the downstream FIFO is not full);
    // wr_en_o qualifies pckt_o for exactly the cycle it is high, with no ready back.
    logic [PORT_N-1:0]        req_i;
    logic [PCKT_W*PORT_N-1:0] pckt_i;
    logic                     nxt_fifo_full_i;
    logic                     nxt_fifo_overflow_i;
    logic [PORT_N-1:0]        rd_en_o;
    logic                     wr_en_o;
    logic [PCKT_W-1:0]        pckt_o;
    logic                     err_o;

    modport master (
        input  req_i, pckt_i, nxt_fifo_full_i, nxt_fifo_overflow_i,
        output rd_en_o, wr_en_o, pckt_o, err_o
    );

    modport slave (
        output req_i, pckt_i, nxt_fifo_full_i, nxt_fifo_overflow_i,
        input  rd_en_o, wr_en_o, pckt_o, err_o
    );
endinterface

// File: rtl/xy_out_arbiter.sv
// Round-robin output-port arbiter with a registered write stage and sticky overflow flag.
// Optional stall-cycle counter (stall_cnt_o) is compiled in with XY_ARB_STALL_CNT_EN.
module xy_out_arbiter #(
    parameter int PORT_N      = 5,
    parameter int PCKT_W      = 16,
    parameter int STALL_CNT_W = 16
) (
    input logic              clk_i,
    input logic              rst_i,
    xy_out_arbiter_if.master arb
`ifdef XY_ARB_STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
`endif
);
    localparam int IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
    localparam logic [IDX_W:0] PORT_N_X = (IDX_W+1)'(PORT_N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PORT_N - 1);

    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    scan_idx;
    logic              win_found;
    logic              grant;
    logic [PORT_N-1:0] rd_en;
    logic              wr_en_q, wr_en_d;
    logic [PCKT_W-1:0] pckt_q, pckt_d;
    logic              err_q, err_d;

    // Scan from ptr upward; the wrapped index never exceeds 2*PORT_N-2, so one subtract suffices.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        scan_idx  = '0;
        for (int k = 0; k < PORT_N; k++) begin
            scan_idx = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= PORT_N_X) begin
                scan_idx = scan_idx - PORT_N_X;
            end
            if (!win_found && arb.req_i[scan_idx[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_idx[IDX_W-1:0];
            end
        end
    end

    assign grant = win_found && !arb.nxt_fifo_full_i && !rst_i;

    always_comb begin
        rd_en = '0;
        if (grant) begin
            rd_en[win_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d   = ptr_q;
        wr_en_d = 1'b0;
        pckt_d  = pckt_q;
        err_d   = err_q | arb.nxt_fifo_overflow_i;
        if (grant) begin
            wr_en_d = 1'b1;
            pckt_d  = arb.pckt_i[PCKT_W*win_idx +: PCKT_W];
            ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q   <= '0;
            wr_en_q <= 1'b0;
            pckt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            wr_en_q <= wr_en_d;
            pckt_q  <= pckt_d;
            err_q   <= err_d;
        end
    end

    assign arb.rd_en_o = rd_en;
    assign arb.wr_en_o = wr_en_q;
    assign arb.pckt_o  = pckt_q;
    assign arb.err_o   = err_q;

`ifdef XY_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Counts cycles where some input waits on a full downstream FIFO; saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((|arb.req_i) && arb.nxt_fifo_full_i && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    // Without the stall counter the arbitration path above is unchanged.
`endif

endmodule

// File: tb/tb_xy_out_arbiter.sv
// Scoreboard bench for xy_out_arbiter: a reference round-robin model predicts pops and
// pushes the expected packet, which is popped when the registered write appears.
module tb_xy_out_arbiter;
  localparam int PORT_N = 5;
  localparam int PCKT_W = 16;
  localparam int STALL_CNT_W = 16;

  logic clk;
  logic rst;

  xy_out_arbiter_if #(.PORT_N(PORT_N), .PCKT_W(PCKT_W)) bus ();

`ifdef XY_ARB_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
`endif

  xy_out_arbiter #(
    .PORT_N(PORT_N),
    .PCKT_W(PCKT_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .arb(bus.master)
`ifdef XY_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o(stall_cnt)
`endif
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard and reference model state
  logic [PCKT_W-1:0] exp_q[$];
  int                n_vec;
  int                n_err;
  int                m_ptr;
  logic              m_wr;
  logic [PCKT_W-1:0] m_pckt;
  logic              m_err;
  logic [STALL_CNT_W-1:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check the pop, clock, then check the registered side.
  task automatic run_cycle(input logic [PORT_N-1:0] req, input logic full,
                           input logic ovf, input logic rst_v);
    int w;
    int idx;
    logic g;
    logic [PORT_N-1:0] exp_rd;
    logic [PCKT_W-1:0] slice;
    bus.req_i = req;
    bus.nxt_fifo_full_i = full;
    bus.nxt_fifo_overflow_i = ovf;
    rst = rst_v;
    for (int p = 0; p < PORT_N; p++) begin
      bus.pckt_i[PCKT_W*p +: PCKT_W] = PCKT_W'($urandom_range(0, 65535));
    end
    #2;
    g = (req != '0) && !full && !rst_v;
    exp_rd = '0;
    w = -1;
    if (g) begin
      for (int k = 0; k < PORT_N; k++) begin
        idx = (m_ptr + k) % PORT_N;
        if (w < 0 && req[idx]) w = idx;
      end
      exp_rd[w] = 1'b1;
      slice = bus.pckt_i[PCKT_W*w +: PCKT_W];
      exp_q.push_back(slice);
    end
    check_eq("rd_en", 32'(bus.rd_en_o), 32'(exp_rd));
    @(posedge clk);
    #1;
    if (rst_v) begin
      m_wr = 1'b0;
      m_pckt = '0;
      m_ptr = 0;
      m_err = 1'b0;
      m_cnt = '0;
      exp_q.delete();
    end else begin
      if (g) begin
        m_wr = 1'b1;
        m_pckt = exp_q.pop_front();
        m_ptr = (w + 1) % PORT_N;
      end else begin
        m_wr = 1'b0;
      end
      if (ovf) m_err = 1'b1;
      if (req != '0 && full && m_cnt != '1) m_cnt = m_cnt + 1'b1;
    end
    check_eq("wr_en", 32'(bus.wr_en_o), 32'(m_wr));
    check_eq("pckt_o", 32'(bus.pckt_o), 32'(m_pckt));
    check_eq("err", 32'(bus.err_o), 32'(m_err));
`ifdef XY_ARB_STALL_CNT_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
`endif
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    m_ptr = 0;
    m_wr = 1'b0;
    m_pckt = '0;
    m_err = 1'b0;
    m_cnt = '0;
    bus.pckt_i = '0;

    // reset with every port requesting: no pops
    run_cycle(5'b11111, 1'b0, 1'b0, 1'b1);
    run_cycle(5'b11111, 1'b0, 1'b0, 1'b1);

    // round robin over all ports
    for (int i = 0; i < 6; i++) run_cycle(5'b11111, 1'b0, 1'b0, 1'b0);

    // move ptr to 3 by granting port 2, then wrap and skip
    run_cycle(5'b00100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(5'b00101, 1'b0, 1'b0, 1'b0);

    // backpressure then release
    for (int i = 0; i < 4; i++) run_cycle(5'b00010, 1'b1, 1'b0, 1'b0);
    run_cycle(5'b00010, 1'b0, 1'b0, 1'b0);
    run_cycle(5'b00000, 1'b0, 1'b0, 1'b0);

    // overflow pulse, sticky, second pulse, then reset clears
    run_cycle(5'b00000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) run_cycle(5'b10001, 1'b0, 1'b0, 1'b0);
    run_cycle(5'b00000, 1'b0, 1'b1, 1'b0);
    run_cycle(5'b00000, 1'b0, 1'b0, 1'b1);
    run_cycle(5'b00000, 1'b0, 1'b0, 1'b0);

    // sole requester gets back-to-back writes
    for (int i = 0; i < 3; i++) run_cycle(5'b01000, 1'b0, 1'b0, 1'b0);
    run_cycle(5'b00000, 1'b0, 1'b0, 1'b0);

    // random traffic with occasional full, overflow and mid-run reset
    for (int i = 0; i < 300; i++) begin
      run_cycle(PORT_N'($urandom_range(0, 31)),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 59) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
